// File: rtl/wm8978_i2c_arbiter_if.sv
// Bundle of requester-side and I2C-driver-side signals around the WM8978 I2C arbiter.
// master = arbiter view; slave = requesters plus driver view.
interface wm8978_i2c_arbiter_if;
  logic        cfg_done;
  logic        req0_valid;
  logic [15:0] req0_data;
  logic        req0_ack;
  logic        req0_done;
  logic        req0_err;
  logic        req1_valid;
  logic [15:0] req1_data;
  logic        req1_ack;
  logic        req1_done;
  logic        req1_err;
  logic        i2c_exec;
  logic [15:0] i2c_data;
  logic        i2c_done;
  logic        i2c_ack;
  logic        busy;

  modport master (
    input  cfg_done, req0_valid, req0_data, req1_valid, req1_data, i2c_done, i2c_ack,
    output req0_ack, req0_done, req0_err, req1_ack, req1_done, req1_err,
           i2c_exec, i2c_data, busy
  );

  modport slave (
    output cfg_done, req0_valid, req0_data, req1_valid, req1_data, i2c_done, i2c_ack,
    input  req0_ack, req0_done, req0_err, req1_ack, req1_done, req1_err,
           i2c_exec, i2c_data, busy
  );
endinterface

// File: rtl/wm8978_i2c_arbiter.sv
// Two-port arbiter sharing one WM8978 I2C write driver: boot sequencer (port 0) and
// runtime requester (port 1, locked out until cfg_done), round-robin afterwards.
module wm8978_i2c_arbiter #(
  parameter int unsigned TIMEOUT = 16'd50000,
  parameter int unsigned CNT_W   = 16
) (
  input  logic                clk,
  input  logic                rst,
  wm8978_i2c_arbiter_if.master bus
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE} state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  state_t             r_state;
  logic               r_owner;
  logic               r_last;
  logic [CNT_W-1:0]   r_cnt;
  logic [15:0]        r_data;
  logic               r_exec;
  logic               r_ack0;
  logic               r_ack1;
  logic               r_done0;
  logic               r_done1;
  logic               r_err0;
  logic               r_err1;
  logic               r_busy;

  state_t             w_state_nxt;
  logic               w_owner_nxt;
  logic               w_last_nxt;
  logic [CNT_W-1:0]   w_cnt_nxt;
  logic [15:0]        w_data_nxt;
  logic               w_exec_nxt;
  logic               w_ack0_nxt;
  logic               w_ack1_nxt;
  logic               w_done0_nxt;
  logic               w_done1_nxt;
  logic               w_err0_nxt;
  logic               w_err1_nxt;

  logic               w_elig0;
  logic               w_elig1;
  logic               w_win;
  logic               w_errv;

  assign w_elig0 = bus.req0_valid;
  assign w_elig1 = bus.req1_valid & bus.cfg_done;
  // On a tie the port that was not granted last wins; otherwise the lone eligible port.
  assign w_win   = (w_elig0 & w_elig1) ? ~r_last : w_elig1;
  // A driver completion beats a simultaneous timeout.
  assign w_errv  = bus.i2c_done ? bus.i2c_ack : 1'b1;

  always_comb begin
    w_state_nxt = r_state;
    w_owner_nxt = r_owner;
    w_last_nxt  = r_last;
    w_cnt_nxt   = r_cnt;
    w_data_nxt  = r_data;
    w_exec_nxt  = 1'b0;
    w_ack0_nxt  = 1'b0;
    w_ack1_nxt  = 1'b0;
    w_done0_nxt = 1'b0;
    w_done1_nxt = 1'b0;
    w_err0_nxt  = 1'b0;
    w_err1_nxt  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_elig0 || w_elig1) begin
          w_state_nxt = S_ISSUE;
          w_owner_nxt = w_win;
          w_last_nxt  = w_win;
          w_data_nxt  = w_win ? bus.req1_data : bus.req0_data;
          w_exec_nxt  = 1'b1;
          w_ack0_nxt  = ~w_win;
          w_ack1_nxt  = w_win;
        end
      end
      S_ISSUE: begin
        w_state_nxt = S_WAIT;
        w_cnt_nxt   = '0;
      end
      S_WAIT: begin
        w_cnt_nxt = r_cnt + CNT_W'(1);
        if (bus.i2c_done || (r_cnt == CNT_LAST)) begin
          w_state_nxt = S_DONE;
          w_done0_nxt = ~r_owner;
          w_done1_nxt = r_owner;
          w_err0_nxt  = ~r_owner & w_errv;
          w_err1_nxt  = r_owner & w_errv;
        end
      end
      S_DONE: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_owner <= 1'b0;
      r_last  <= 1'b1;
      r_cnt   <= '0;
      r_data  <= '0;
      r_exec  <= 1'b0;
      r_ack0  <= 1'b0;
      r_ack1  <= 1'b0;
      r_done0 <= 1'b0;
      r_done1 <= 1'b0;
      r_err0  <= 1'b0;
      r_err1  <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_owner <= w_owner_nxt;
      r_last  <= w_last_nxt;
      r_cnt   <= w_cnt_nxt;
      r_data  <= w_data_nxt;
      r_exec  <= w_exec_nxt;
      r_ack0  <= w_ack0_nxt;
      r_ack1  <= w_ack1_nxt;
      r_done0 <= w_done0_nxt;
      r_done1 <= w_done1_nxt;
      r_err0  <= w_err0_nxt;
      r_err1  <= w_err1_nxt;
      r_busy  <= (w_state_nxt != S_IDLE);
    end
  end

  assign bus.i2c_exec  = r_exec;
  assign bus.i2c_data  = r_data;
  assign bus.req0_ack  = r_ack0;
  assign bus.req1_ack  = r_ack1;
  assign bus.req0_done = r_done0;
  assign bus.req1_done = r_done1;
  assign bus.req0_err  = r_err0;
  assign bus.req1_err  = r_err1;
  assign bus.busy      = r_busy;

endmodule
